// File: rtl/pp_gen_pkg.sv
// Shared types, constants and saturating level arithmetic for the
// peak-to-peak stimulus generator.
package pp_gen_pkg;

    localparam int DW = 12;
    localparam logic [DW-1:0] LVL_MAX = 12'd4095;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DW]) begin
            return LVL_MAX;
        end else begin
            return sum[DW-1:0];
        end
    endfunction

    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[DW]) begin
            return {DW{1'b0}};
        end else begin
            return diff[DW-1:0];
        end
    endfunction

    // An empty or inverted window pins the amplitude to its lower limit.
    function automatic logic [DW-1:0] clamp_amp(input logic [DW-1:0] x,
                                                input logic [DW-1:0] lo,
                                                input logic [DW-1:0] hi);
        if (hi <= lo) begin
            return lo;
        end else if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/pp_gen_tick.sv
// Sample-period divider with a floor on the period, plus the delayed
// fixed-width sample strobe that follows each data update.
module pp_tick_div #(
    parameter int SETUP = 2,
    parameter int PLS_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] cfg_div,
    output logic        tick,
    output logic        pls
);

    localparam logic [15:0] DIV_MIN = 16'(SETUP + PLS_W + 1);
    localparam logic [7:0]  PH_ON   = 8'(SETUP);
    localparam logic [7:0]  PH_END  = 8'(SETUP + PLS_W - 1);

    logic [15:0] cnt_q, cnt_d, div_eff_s;
    logic        busy_q, busy_d;
    logic [7:0]  ph_q, ph_d, ph_nx_s;
    logic        pls_q, pls_d;

    // Divider: counts only while enabled; >= keeps a shrunken period safe.
    always_comb begin
        div_eff_s = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
        tick      = en && (cnt_q >= (div_eff_s - 16'd1));
        if (!en) begin
            cnt_d = cnt_q;
        end else if (tick) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Pulse shaper: ph counts clocks since the data update, independent of en.
    always_comb begin
        ph_nx_s = ph_q + 8'd1;
        busy_d  = busy_q;
        ph_d    = ph_q;
        pls_d   = 1'b0;
        if (tick) begin
            busy_d = 1'b1;
            ph_d   = 8'd0;
        end else if (busy_q) begin
            ph_d  = ph_nx_s;
            pls_d = (ph_nx_s >= PH_ON) && (ph_nx_s <= PH_END);
            if (ph_q == PH_END) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 16'd0;
            busy_q <= 1'b0;
            ph_q   <= 8'd0;
            pls_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ph_q   <= ph_d;
            pls_q  <= pls_d;
        end
    end

    assign pls = pls_q;

endmodule

// File: rtl/pp_gen.sv
// Triangle amplitude sweep generator driving a top/bottom level pair and a
// sample strobe for self-test of the peak-to-peak detector.
module pp_gen
    import pp_gen_pkg::*;
#(
    parameter int SETUP = 2,
    parameter int PLS_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [15:0]   cfg_div,
    input  logic [DW-1:0] cfg_base,
    input  logic [DW-1:0] cfg_amin,
    input  logic [DW-1:0] cfg_amax,
    input  logic [DW-1:0] cfg_step,
    input  logic [5:0]    cfg_hold,
    output logic          pls,
    output logic          rf_up_dn,
    output logic [DW-1:0] rf_pp_top,
    output logic [DW-1:0] rf_pp_btm,
    output logic          dir,
    output logic [15:0]   peak_cnt
);

    state_e        state_q, state_d;
    logic [DW-1:0] amp_q, amp_d;
    logic [5:0]    hcnt_q, hcnt_d;
    logic [15:0]   peak_q, peak_d;
    logic [DW-1:0] top_q, top_d, btm_q, btm_d;
    logic          up_dn_q, up_dn_d, dir_q, dir_d;
    logic          tick_s;
    logic [DW-1:0] amp_up_s, amp_dn_s, amp_hold_s;

    pp_tick_div #(
        .SETUP (SETUP),
        .PLS_W (PLS_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_div (cfg_div),
        .tick    (tick_s),
        .pls     (pls)
    );

    // Sweep FSM and output data, all advanced only on a divider tick.
    always_comb begin
        amp_up_s   = clamp_amp(sat_add(amp_q, cfg_step), cfg_amin, cfg_amax);
        amp_dn_s   = clamp_amp(sat_sub(amp_q, cfg_step), cfg_amin, cfg_amax);
        amp_hold_s = clamp_amp(amp_q, cfg_amin, cfg_amax);
        state_d    = state_q;
        amp_d      = amp_q;
        hcnt_d     = hcnt_q;
        peak_d     = peak_q;
        top_d      = top_q;
        btm_d      = btm_q;
        up_dn_d    = up_dn_q;
        dir_d      = dir_q;
        if (tick_s) begin
            case (state_q)
                IDLE: begin
                    amp_d   = cfg_amin;
                    state_d = RISE;
                end
                RISE: begin
                    amp_d = amp_up_s;
                    if (amp_up_s >= cfg_amax) begin
                        if (cfg_hold == 6'd0) begin
                            state_d = FALL;
                        end else begin
                            state_d = HOLD_HI;
                            hcnt_d  = 6'd1;
                        end
                    end else begin
                        state_d = RISE;
                    end
                end
                HOLD_HI: begin
                    amp_d = amp_hold_s;
                    if (hcnt_q >= cfg_hold) begin
                        state_d = FALL;
                    end else begin
                        hcnt_d = hcnt_q + 6'd1;
                    end
                end
                FALL: begin
                    amp_d = amp_dn_s;
                    if (amp_dn_s <= cfg_amin) begin
                        peak_d = peak_q + 16'd1;
                        if (cfg_hold == 6'd0) begin
                            state_d = RISE;
                        end else begin
                            state_d = HOLD_LO;
                            hcnt_d  = 6'd1;
                        end
                    end else begin
                        state_d = FALL;
                    end
                end
                HOLD_LO: begin
                    amp_d = amp_hold_s;
                    if (hcnt_q >= cfg_hold) begin
                        state_d = RISE;
                    end else begin
                        hcnt_d = hcnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    amp_d   = {DW{1'b0}};
                end
            endcase
            // dir reports the phase that produced the sample now on the outputs.
            top_d   = sat_add(cfg_base, amp_d);
            btm_d   = cfg_base;
            up_dn_d = ~up_dn_q;
            dir_d   = (state_q == IDLE) || (state_q == RISE) || (state_q == HOLD_HI);
        end else begin
            state_d = state_q;
        end
    end

    // Sweep and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            amp_q   <= {DW{1'b0}};
            hcnt_q  <= 6'd0;
            peak_q  <= 16'd0;
            top_q   <= {DW{1'b0}};
            btm_q   <= {DW{1'b0}};
            up_dn_q <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            hcnt_q  <= hcnt_d;
            peak_q  <= peak_d;
            top_q   <= top_d;
            btm_q   <= btm_d;
            up_dn_q <= up_dn_d;
            dir_q   <= dir_d;
        end
    end

    assign rf_up_dn  = up_dn_q;
    assign rf_pp_top = top_q;
    assign rf_pp_btm = btm_q;
    assign dir       = dir_q;
    assign peak_cnt  = peak_q;

endmodule

// File: tb/tb_pp_gen.sv
// Bench for pp_gen: scenario table with expected amplitude sequences,
// hand-written freeze/reset sequences, and randomized runs against a sample model.
module tb_pp_gen;

    localparam int SETUP = 2;
    localparam int PLS_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] cfg_div = 16'd8;
    logic [11:0] cfg_base = 12'd0, cfg_amin = 12'd0, cfg_amax = 12'd0, cfg_step = 12'd0;
    logic [5:0]  cfg_hold = 6'd0;
    logic        pls, rf_up_dn, dir;
    logic [11:0] rf_pp_top, rf_pp_btm;
    logic [15:0] peak_cnt;

    pp_gen #(.SETUP(SETUP), .PLS_W(PLS_W)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_div(cfg_div), .cfg_base(cfg_base),
        .cfg_amin(cfg_amin), .cfg_amax(cfg_amax), .cfg_step(cfg_step), .cfg_hold(cfg_hold),
        .pls(pls), .rf_up_dn(rf_up_dn), .rf_pp_top(rf_pp_top), .rf_pp_btm(rf_pp_btm),
        .dir(dir), .peak_cnt(peak_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Behavioural model: one sample per effective period of enabled clocks.
    int m_cnt, m_since, m_samples;
    bit m_started, m_up, m_dir, m_tog;
    int m_amp, m_hold_left, m_peaks, m_top, m_btm;

    typedef struct {
        int base; int amin; int amax; int step; int hold; int div;
        int n; int per; int peak;
        int exp [16];
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int clampm(input int x);
        int lo = int'(cfg_amin);
        int hi = int'(cfg_amax);
        if (hi <= lo) return lo;
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_since = -1; m_samples = 0; m_started = 0; m_up = 1; m_dir = 1;
        m_tog = 0; m_amp = 0; m_hold_left = 0; m_peaks = 0; m_top = 0; m_btm = 0;
    endtask

    task automatic model_sample();
        int v;
        if (!m_started) begin
            m_started = 1; m_up = 1; m_dir = 1; m_hold_left = 0;
            m_amp = clampm(int'(cfg_amin));
        end else if (m_hold_left > 0) begin
            m_dir = m_up;
            m_amp = clampm(m_amp);
            m_hold_left--;
            if (m_hold_left == 0) m_up = !m_up;
        end else if (m_up) begin
            m_dir = 1;
            v = m_amp + int'(cfg_step);
            if (v > 4095) v = 4095;
            m_amp = clampm(v);
            if (m_amp >= int'(cfg_amax)) begin
                if (cfg_hold == 0) m_up = 0;
                else m_hold_left = int'(cfg_hold);
            end
        end else begin
            m_dir = 0;
            v = m_amp - int'(cfg_step);
            if (v < 0) v = 0;
            m_amp = clampm(v);
            if (m_amp <= int'(cfg_amin)) begin
                m_peaks = (m_peaks + 1) % 65536;
                if (cfg_hold == 0) m_up = 1;
                else m_hold_left = int'(cfg_hold);
            end
        end
        m_btm = int'(cfg_base);
        m_top = (m_btm + m_amp > 4095) ? 4095 : m_btm + m_amp;
        m_tog = !m_tog;
        m_samples++;
    endtask

    task automatic model_step();
        int per;
        per = (int'(cfg_div) < SETUP + PLS_W + 1) ? SETUP + PLS_W + 1 : int'(cfg_div);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_since >= 0 && m_since < 1000) m_since++;
            if (en) begin
                if (m_cnt >= per - 1) begin
                    m_cnt = 0;
                    m_since = 0;
                    model_sample();
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pls", int'(pls), (m_since >= SETUP && m_since < SETUP + PLS_W) ? 1 : 0);
        chk("rf_up_dn", int'(rf_up_dn), int'(m_tog));
        chk("rf_pp_top", int'(rf_pp_top), m_top);
        chk("rf_pp_btm", int'(rf_pp_btm), m_btm);
        chk("dir", int'(dir), int'(m_dir));
        chk("peak_cnt", int'(peak_cnt), m_peaks);
    endtask

    task automatic set_cfg(input int base, input int amin, input int amax,
                           input int step, input int hold, input int div);
        cfg_base = 12'(base); cfg_amin = 12'(amin); cfg_amax = 12'(amax);
        cfg_step = 12'(step); cfg_hold = 6'(hold); cfg_div = 16'(div);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pls"}, int'(pls), 0);
        chk({tag, "_top"}, int'(rf_pp_top), 0);
        chk({tag, "_btm"}, int'(rf_pp_btm), 0);
        chk({tag, "_updn"}, int'(rf_up_dn), 0);
        chk({tag, "_dir"}, int'(dir), 1);
        chk({tag, "_peak"}, int'(peak_cnt), 0);
    endtask

    // Runs until the DUT toggles rf_up_dn or the budget expires; returns 1 on toggle.
    task automatic wait_toggle(input int budget, output bit found);
        logic prev;
        prev = rf_up_dn;
        found = 0;
        for (int c = 0; c < budget && !found; c++) begin
            cyc();
            if (rf_up_dn !== prev) found = 1;
        end
    endtask

    initial begin
        bit found;
        logic tog;
        bit pls_seen;

        vecs[0] = '{100, 0, 40, 10, 0, 8, 10, 8, 1, '{0,10,20,30,40,30,20,10,0,10,0,0,0,0,0,0}};
        vecs[1] = '{100, 0, 40, 10, 2, 8, 14, 8, 1, '{0,10,20,30,40,40,40,30,20,10,0,0,0,10,0,0}};
        vecs[2] = '{100, 0, 40, 15, 0, 8, 7, 8, 1, '{0,15,30,40,25,10,0,0,0,0,0,0,0,0,0,0}};
        vecs[3] = '{4090, 0, 40, 10, 0, 8, 10, 8, 1, '{0,5,5,5,5,5,5,5,0,5,0,0,0,0,0,0}};
        vecs[4] = '{100, 0, 40, 10, 0, 1, 6, 5, 0, '{0,10,20,30,40,30,0,0,0,0,0,0,0,0,0,0}};
        vecs[5] = '{200, 50, 30, 10, 0, 6, 6, 6, 2, '{50,50,50,50,50,50,0,0,0,0,0,0,0,0,0,0}};
        vecs[6] = '{300, 20, 60, 0, 1, 5, 5, 5, 0, '{20,20,20,20,20,0,0,0,0,0,0,0,0,0,0,0}};

        model_reset();
        en = 1'b1;
        do_reset();
        check_reset_vals("reset");

        // Scenario table: amplitude sequence, sample spacing and final peak count.
        for (int i = 0; i < 7; i++) begin
            int got, last, bound;
            logic prev;
            set_cfg(vecs[i].base, vecs[i].amin, vecs[i].amax, vecs[i].step, vecs[i].hold, vecs[i].div);
            en = 1'b1;
            do_reset();
            got = 0; last = -1; prev = rf_up_dn;
            bound = vecs[i].n * vecs[i].per + 30;
            for (int c = 0; c < bound && got < vecs[i].n; c++) begin
                cyc();
                if (rf_up_dn !== prev) begin
                    chk($sformatf("vec%0d_amp%0d", i, got), int'(rf_pp_top) - int'(rf_pp_btm), vecs[i].exp[got]);
                    if (last >= 0) chk($sformatf("vec%0d_period", i), c - last, vecs[i].per);
                    last = c;
                    prev = rf_up_dn;
                    got++;
                end
            end
            chk($sformatf("vec%0d_samples", i), got, vecs[i].n);
            chk($sformatf("vec%0d_peak", i), int'(peak_cnt), vecs[i].peak);
        end

        // Freeze mid-RISE: no strobe or toggle while en is low, then the sweep resumes.
        set_cfg(100, 0, 40, 10, 0, 8);
        en = 1'b1;
        do_reset();
        for (int c = 0; c < 100 && m_samples < 3; c++) cyc();
        chk("freeze_reach", m_samples, 3);
        repeat (6) cyc();
        en = 1'b0;
        tog = rf_up_dn;
        pls_seen = 0;
        repeat (20) begin
            cyc();
            if (pls) pls_seen = 1;
        end
        chk("freeze_pls", int'(pls_seen), 0);
        chk("freeze_tog", int'(rf_up_dn), int'(tog));
        en = 1'b1;
        wait_toggle(20, found);
        chk("freeze_resume_seen", int'(found), 1);
        chk("freeze_resume_amp", int'(rf_pp_top) - int'(rf_pp_btm), 30);

        // Reset during HOLD_HI while pls is high, then restart from amin.
        set_cfg(100, 10, 40, 10, 2, 8);
        en = 1'b1;
        do_reset();
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            cyc();
            if (m_samples == 4 && pls) found = 1;
        end
        chk("hold_pls_reached", int'(found), 1);
        rst = 1'b0;
        cyc();
        check_reset_vals("midrst");
        rst = 1'b1;
        wait_toggle(20, found);
        chk("midrst_restart_seen", int'(found), 1);
        chk("midrst_first_amp", int'(rf_pp_top) - int'(rf_pp_btm), 10);

        // Randomized configurations with random enable gaps.
        for (int r = 0; r < 8; r++) begin
            set_cfg($urandom_range(0, 4095), $urandom_range(0, 300), $urandom_range(0, 400),
                    $urandom_range(0, 60), $urandom_range(0, 3), $urandom_range(1, 9));
            en = 1'b1;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                en = ($urandom_range(0, 7) != 0);
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pp_gen.md
Name: pp_gen

Overview:
- Stimulus and calibration source for the peak-to-peak detector block.
- Produces a sample strobe `pls` and a sample-toggle flag `rf_up_dn`.
- Produces a top/bottom level pair `rf_pp_top`/`rf_pp_btm` whose difference sweeps as a triangle between programmable limits.
- Used for in-system self-test and for bench loop-back against the detector.

Parameters:
- SETUP, 2, clocks between the sample-data update and the `pls` rising edge.
- PLS_W, 2, `pls` high width in clocks.
- DW, 12, level width (fixed 12 for the detector interface).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  run enable; low freezes the generator.
- cfg_div  in  16  sample period in clocks.
- cfg_base  in  12  bottom level driven on `rf_pp_btm`.
- cfg_amin  in  12  minimum amplitude (top minus bottom).
- cfg_amax  in  12  maximum amplitude.
- cfg_step  in  12  amplitude increment per sample.
- cfg_hold  in  6  extra flat samples at each extreme.
- pls  out  1  sample strobe.
- rf_up_dn  out  1  toggles once per new sample.
- rf_pp_top  out  12  top level.
- rf_pp_btm  out  12  bottom level.
- dir  out  1  1 = rising/high-hold, 0 = falling/low-hold.
- peak_cnt  out  16  completed triangle periods.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, amp=0, rf_pp_top=0, rf_pp_btm=0.
  - rf_up_dn=0, pls=0, dir=1, peak_cnt=0.
  - Divider count=0, hold count=0.
  - Takes effect on the next edge, including mid-sweep or mid-pulse.
- Effective period DIV = max(cfg_div, SETUP+PLS_W+1), giving 5 by default.
- Divider counts 0..DIV-1 while en=1. Tick = count==DIV-1.
- On tick, one clock later (registered):
  - amp and state update.
  - rf_pp_btm <= cfg_base.
  - rf_pp_top <= min(cfg_base+amp_next, 4095), computed 13-bit then saturated.
  - rf_up_dn toggles.
  - Data then holds stable until the next tick update.
- pls rises SETUP clocks after the data update and stays high PLS_W clocks. Exactly one pulse per tick.
- Amplitude arithmetic is 13-bit internally with saturation. amp_next is always clamped into [cfg_amin, cfg_amax].
- State transitions (evaluated on tick only):
  - IDLE: amp<=cfg_amin, go to RISE (first sample = amin).
  - RISE: amp<=min(amp+step, amax). If the result equals amax: go to FALL when cfg_hold=0, else go to HOLD_HI with hcnt=1.
  - HOLD_HI: amp unchanged. If hcnt==cfg_hold go to FALL, else hcnt++.
  - FALL: amp<=max(amp-step, amin), with saturating subtract. If the result equals amin: peak_cnt++ (wraps at 65535→0), then go to RISE if cfg_hold=0, else go to HOLD_LO with hcnt=1.
  - HOLD_LO: mirror of HOLD_HI, exiting to RISE.
- dir = 1 in IDLE/RISE/HOLD_HI, 0 in FALL/HOLD_LO.
- Boundary conditions:
  - cfg_amax<=cfg_amin: amp pinned to cfg_amin. State alternates RISE/FALL (or via the holds) every sample, and peak_cnt increments every FALL sample.
  - cfg_step=0: amp frozen, state remains RISE. Strobes continue.
  - en=0: divider, state and outputs hold. Any pls in progress completes its PLS_W width. No new tick is generated. Resume continues from the frozen count.
  - Config changes take effect at the next tick only.

Decomposition:
- Package pp_gen_pkg holds:
  - state enum {IDLE, RISE, HOLD_HI, FALL, HOLD_LO};
  - constants LVL_MAX=4095 and DW=12;
  - the saturating add/sub functions.
- Sub-module pp_tick_div:
  - divider and DIV clamp;
  - tick generation;
  - SETUP delay and PLS_W pulse shaper.
- Top level holds the sweep FSM and the output registers.

Test Plan:
- Basic triangle: base=100, amin=0, amax=40, step=10, hold=0, div=8.
  - top-btm sequence is 0,10,20,30,40,30,20,10,0,10…
  - rf_up_dn toggles each sample.
  - pls is high 2 clocks, rising 2 clocks after each update, period 8.
  - peak_cnt=1 after the second 0.
- Hold: same config with hold=2 → 40 appears on 3 consecutive samples and 0 on 3 consecutive samples (after the first period). dir falls on the first 30.
- Clamp: step=15, amax=40 → 0,15,30,40,25,10,0.
- Top saturation: base=4090, amax=40 → rf_pp_top stays at 4095 once amp≥5, and rf_pp_btm=4090.
- Freeze and divider clamp:
  - en low for 20 clocks mid-RISE → no pls and no rf_up_dn toggle; the next sample continues the sequence unchanged.
  - cfg_div=1 → period measured as 5 clocks.
- Reset mid-operation: rst low during HOLD_HI with pls high → on the next edge all outputs take their reset values; after release the first sample = amin.
